qeciphy_rx_word_aligner: RTL



---
 rtl/qeciphy_rx_word_aligner.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/qeciphy_rx_word_aligner.sv
// qeciphy_rx_word_aligner: slides the GTY RX until K28.5 sits in byte lane 0.
// Define QECIPHY_RX_ALIGN_STATS_EN to add lock-loss and code-error counters.
module qeciphy_rx_word_aligner #(
    parameter logic [7:0] COMMA_CHAR    = 8'hBC,
    parameter int         SEARCH_WINDOW = 64,
    parameter int         SLIDE_WAIT    = 32,
    parameter int         LOCK_COUNT    = 4,
    parameter int         ERR_LIMIT     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data_i,
    input  logic [3:0]  rx_charisk_i,
    input  logic [3:0]  rx_disperr_i,
    input  logic [3:0]  rx_notintable_i,
    output logic        rx_slide_o,
    output logic        aligned_o,
    output logic [31:0] rx_data_o,
    output logic [3:0]  rx_charisk_o,
    output logic        rx_valid_o,
    output logic [7:0]  slide_count_o
`ifdef QECIPHY_RX_ALIGN_STATS_EN
    ,
    output logic [15:0] lock_loss_count_o,
    output logic [15:0] code_err_count_o
`endif
);

    localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
    localparam int WAIT_W = $clog2(SLIDE_WAIT + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_SLIDE,
        S_WAIT,
        S_CHECK,
        S_LOCKED
    } state_t;

    state_t state_q, state_d;

    logic [WIN_W-1:0]  window_q, window_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [7:0]        slide_cnt_q;
    logic [31:0]       data_q;
    logic [3:0]        charisk_q;

    logic comma0;
    logic comma_x;
    logic code_err;

    always_comb begin
        comma0  = rx_charisk_i[0] && (rx_data_i[7:0] == COMMA_CHAR);
        comma_x = 1'b0;
        for (int b = 1; b < 4; b++) begin
            if (rx_charisk_i[b] && (rx_data_i[8*b +: 8] == COMMA_CHAR)) begin
                comma_x = 1'b1;
            end
        end
        code_err = |(rx_disperr_i | rx_notintable_i);
    end

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        wait_d   = wait_q;
        good_d   = good_q;
        err_d    = err_q;
        unique case (state_q)
            S_HUNT: begin
                if (comma_x) begin
                    state_d  = S_SLIDE;
                    window_d = '0;
                end else if (comma0 && !code_err) begin
                    state_d  = (LOCK_COUNT == 1) ? S_LOCKED : S_CHECK;
                    good_d   = GOOD_W'(1);
                    err_d    = '0;
                    window_d = '0;
                end else if (window_q == WIN_W'(SEARCH_WINDOW - 1)) begin
                    state_d  = S_SLIDE;
                    window_d = '0;
                end else begin
                    window_d = window_q + 1'b1;
                end
            end
            S_SLIDE: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (wait_q == WAIT_W'(SLIDE_WAIT - 1)) begin
                    state_d  = S_HUNT;
                    window_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (comma_x || code_err) begin
                    state_d  = S_SLIDE;
                    good_d   = '0;
                    window_d = '0;
                end else if (comma0) begin
                    window_d = '0;
                    if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                        state_d = S_LOCKED;
                        good_d  = '0;
                        err_d   = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end else if (window_q == WIN_W'(SEARCH_WINDOW - 1)) begin
                    // Comma stream vanished before lock was confirmed.
                    state_d  = S_HUNT;
                    good_d   = '0;
                    window_d = '0;
                end else begin
                    window_d = window_q + 1'b1;
                end
            end
            S_LOCKED: begin
                if (comma_x || code_err) begin
                    if (err_q == ERR_W'(ERR_LIMIT - 1)) begin
                        state_d  = S_HUNT;
                        err_d    = '0;
                        window_d = '0;
                    end else begin
                        err_d = err_q + 1'b1;
                    end
                end else begin
                    err_d = '0;
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            window_q    <= '0;
            wait_q      <= '0;
            good_q      <= '0;
            err_q       <= '0;
            slide_cnt_q <= '0;
            data_q      <= '0;
            charisk_q   <= '0;
        end else begin
            state_q   <= state_d;
            window_q  <= window_d;
            wait_q    <= wait_d;
            good_q    <= good_d;
            err_q     <= err_d;
            data_q    <= rx_data_i;
            charisk_q <= rx_charisk_i;
            if (state_q == S_SLIDE && slide_cnt_q != 8'hFF) begin
                slide_cnt_q <= slide_cnt_q + 8'd1;
            end
        end
    end

    assign rx_slide_o    = (state_q == S_SLIDE);
    assign aligned_o     = (state_q == S_LOCKED);
    assign rx_valid_o    = aligned_o;
    assign rx_data_o     = data_q;
    assign rx_charisk_o  = charisk_q;
    assign slide_count_o = slide_cnt_q;

`ifdef QECIPHY_RX_ALIGN_STATS_EN
    logic [15:0] loss_q;
    logic [15:0] cerr_q;
    logic        loss_evt;

    assign loss_evt = (state_q == S_LOCKED) && (state_d == S_HUNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loss_q <= '0;
            cerr_q <= '0;
        end else begin
            if (loss_evt && loss_q != 16'hFFFF) begin
                loss_q <= loss_q + 16'd1;
            end
            if (code_err && aligned_o && cerr_q != 16'hFFFF) begin
                cerr_q <= cerr_q + 16'd1;
            end
        end
    end

    assign lock_loss_count_o = loss_q;
    assign code_err_count_o  = cerr_q;
`endif

endmodule
